ti_clk_ctrl: RTL

TI_CLK_CTRL -- requirements
Module: ti_clk_ctrl

---
 rtl/ti_pkg.sv | 16 +
 rtl/ti_step_edge.sv | 24 ++
 rtl/ti_clk_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ti_pkg.sv
// Shared types and constants for the task-interruption clock controller.
package ti_pkg;

    localparam int unsigned CYCLE_W     = 32;
    localparam int unsigned DRAIN_CNT_W = 8;

    localparam logic [CYCLE_W-1:0] BP_DISABLED = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StHalt,
        StStep
    } ti_state_e;

endpackage

// File: rtl/ti_step_edge.sv
// Rising-edge detector for two step sources; simultaneous edges merge into one pulse.
module ti_step_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic step_a_i,
    input  logic step_b_i,
    output logic pulse_o
);

    logic prev_a_q, prev_b_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_a_q <= 1'b0;
            prev_b_q <= 1'b0;
        end else begin
            prev_a_q <= step_a_i;
            prev_b_q <= step_b_i;
        end
    end

    assign pulse_o = (step_a_i & ~prev_a_q) | (step_b_i & ~prev_b_q);

endmodule

// File: rtl/ti_clk_ctrl.sv
// Clock-enable controller with task interruption, drain, single-step and breakpoint halt.
// Breakpoint logic is present only when TI_BREAKPOINT_EN is defined.
module ti_clk_ctrl
    import ti_pkg::*;
#(
    parameter int unsigned DRAIN_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    input  logic               ti_req,
    input  logic               pr_done,
    input  logic               clk_step,
    input  logic               clk_step_1,
    input  logic [CYCLE_W-1:0] breakpoint,
    input  logic               idle_in,
    output logic               ce,
    output logic               ti_gnt,
    output logic [CYCLE_W-1:0] cycle_cnt,
    output logic               bp_hit,
    output logic               drain_to
);

    localparam logic [DRAIN_CNT_W-1:0] DrainLast = DRAIN_CNT_W'(DRAIN_TIMEOUT - 1);

    ti_state_e              state_q, state_d;
    logic                   ce_q, ce_d;
    logic                   gnt_q, gnt_d;
    logic [CYCLE_W-1:0]     cnt_q, cnt_d;
    logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic                   drain_to_q, drain_to_d;
    logic                   step_pulse;
    logic                   bp_match;
    logic                   bp_set;
    logic                   resume;

    ti_step_edge u_step_edge (
        .clk_i   (clk),
        .rst_i   (rst),
        .step_a_i(clk_step),
        .step_b_i(clk_step_1),
        .pulse_o (step_pulse)
    );

    assign cnt_d = cnt_q + {{(CYCLE_W-1){1'b0}}, ce_q};

`ifdef TI_BREAKPOINT_EN
    logic bp_hit_q, bp_hit_d;
    logic bp_armed_q, bp_armed_d;

    // Compare against the next count so the halt lands exactly on the breakpoint value.
    assign bp_match = bp_armed_q && (breakpoint != BP_DISABLED) && (cnt_d == breakpoint);

    always_comb begin
        bp_hit_d   = bp_hit_q;
        bp_armed_d = bp_armed_q;
        if (ce_q) begin
            bp_armed_d = 1'b1;
        end
        if (bp_set) begin
            bp_hit_d   = 1'b1;
            bp_armed_d = 1'b0;
        end
        if (resume) begin
            bp_hit_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_hit_q   <= 1'b0;
            bp_armed_q <= 1'b1;
        end else begin
            bp_hit_q   <= bp_hit_d;
            bp_armed_q <= bp_armed_d;
        end
    end

    assign bp_hit = bp_hit_q;
`else
    logic unused_bp;
    assign unused_bp = ^{breakpoint, bp_set, resume};
    assign bp_match  = 1'b0;
    assign bp_hit    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ce_d        = 1'b0;
        drain_cnt_d = drain_cnt_q;
        drain_to_d  = drain_to_q;
        bp_set      = 1'b0;
        resume      = 1'b0;
        unique case (state_q)
            StRun: begin
                ce_d = clk_en;
                if (bp_match) begin
                    state_d = StHalt;
                    ce_d    = 1'b0;
                    bp_set  = 1'b1;
                end else if (ti_req) begin
                    state_d     = StDrain;
                    drain_cnt_d = '0;
                end
            end
            StDrain: begin
                ce_d        = 1'b1;
                drain_cnt_d = drain_cnt_q + 8'd1;
                if (!ti_req) begin
                    state_d = StRun;
                    ce_d    = clk_en;
                end else if (idle_in) begin
                    state_d = StHalt;
                    ce_d    = 1'b0;
                end else if (drain_cnt_q == DrainLast) begin
                    state_d    = StHalt;
                    ce_d       = 1'b0;
                    drain_to_d = 1'b1;
                end
            end
            StHalt: begin
                // Resume takes priority over a step edge in the same cycle.
                if (pr_done && !ti_req) begin
                    state_d    = StRun;
                    drain_to_d = 1'b0;
                    resume     = 1'b1;
                end else if (step_pulse) begin
                    state_d = StStep;
                    ce_d    = 1'b1;
                end
            end
            StStep: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StRun;
            end
        endcase
        gnt_d = (state_d == StHalt) && ti_req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            ce_q        <= 1'b0;
            gnt_q       <= 1'b0;
            cnt_q       <= '0;
            drain_cnt_q <= '0;
            drain_to_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ce_q        <= ce_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            drain_cnt_q <= drain_cnt_d;
            drain_to_q  <= drain_to_d;
        end
    end

    assign ce        = ce_q;
    assign ti_gnt    = gnt_q;
    assign cycle_cnt = cnt_q;
    assign drain_to  = drain_to_q;

endmodule
